lp_box_solver: RTL and testbench

//  Parametrised exhaustive integer solver for a 2-variable LP: maximise c1*x1 + c2*x2

---
 rtl/lp_box_solver.sv | 163 ++++++++++++++++
 tb/tb_lp_box_solver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lp_box_solver.sv
`default_nettype none
// ============================================================================
// lp_box_solver
//   Exhaustive integer solver for a 2-variable LP over a box. It tests one
//   lattice point per cycle against every general constraint in parallel.
//   Revision: 1.0
// ============================================================================
module lp_box_solver #(
  parameter int A_W     = 6,
  parameter int B_W     = 12,
  parameter int NUM_CON = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [A_W-1:0]      in_a1,
  input  logic signed [A_W-1:0]      in_a2,
  input  logic signed [B_W-1:0]      in_b,
  output logic                       out_valid,
  output logic signed [A_W+B_W:0]    out_max_value,
  output logic signed [B_W-1:0]      out_x1,
  output logic signed [B_W-1:0]      out_x2,
  output logic                       out_feasible,
  output logic                       busy
);

  localparam int O_W   = A_W + B_W + 1;
  localparam int CNT_W = $clog2(NUM_CON + 1);
  localparam logic signed [A_W-1:0] c_one  = A_W'(1);
  localparam logic signed [A_W-1:0] c_mone = {A_W{1'b1}};
  localparam logic signed [A_W-1:0] c_zero = '0;
  localparam logic signed [O_W-1:0] c_min  = {1'b1, {(O_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic signed [A_W-1:0] r_c1, r_c2;
  logic signed [B_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic signed [A_W-1:0] r_sa1 [NUM_CON];
  logic signed [A_W-1:0] r_sa2 [NUM_CON];
  logic signed [B_W-1:0] r_sb  [NUM_CON];
  logic [NUM_CON-1:0]    r_sv;
  logic [CNT_W-1:0]      r_nfill;
  logic signed [B_W-1:0] r_x, r_y, r_bx, r_by;
  logic signed [O_W-1:0] r_best;
  logic                  r_found;

  logic signed [O_W-1:0] w_xe, w_ye, w_c1e, w_c2e, w_obj, w_best_n;
  logic signed [B_W-1:0] w_bx_n, w_by_n;
  logic [NUM_CON-1:0]    w_ok;
  logic                  w_feas, w_take, w_found_n, w_last, w_empty;

  assign w_xe  = r_x;
  assign w_ye  = r_y;
  assign w_c1e = r_c1;
  assign w_c2e = r_c2;
  assign w_obj = w_c1e * w_xe + w_c2e * w_ye;

  generate
    for (genvar i = 0; i < NUM_CON; i++) begin : g_slot
      logic signed [O_W-1:0] w_a1e, w_a2e, w_be, w_lhs;
      assign w_a1e  = r_sa1[i];
      assign w_a2e  = r_sa2[i];
      assign w_be   = r_sb[i];
      assign w_lhs  = w_a1e * w_xe + w_a2e * w_ye;
      assign w_ok[i] = !r_sv[i] || (w_lhs <= w_be);
    end
  endgenerate

  assign w_feas    = &w_ok;
  // Strict compare keeps the earliest point on ties.
  assign w_take    = (r_state == S_SCAN) && w_feas && (!r_found || (w_obj > r_best));
  assign w_best_n  = w_take ? w_obj : r_best;
  assign w_bx_n    = w_take ? r_x : r_bx;
  assign w_by_n    = w_take ? r_y : r_by;
  assign w_found_n = r_found || w_take;
  assign w_last    = (r_x == r_xmax) && (r_y == r_ymax);
  assign w_empty   = (r_xmin > r_xmax) || (r_ymin > r_ymax);

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE) || in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_LOAD;
      S_LOAD: if (!in_valid) w_state_nxt = w_empty ? S_DONE : S_SCAN;
      S_SCAN: if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c1 <= '0; r_c2 <= '0;
      r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
      for (int i = 0; i < NUM_CON; i++) begin
        r_sa1[i] <= '0; r_sa2[i] <= '0; r_sb[i] <= '0;
      end
      r_sv <= '0; r_nfill <= '0;
      r_x <= '0; r_y <= '0; r_bx <= '0; r_by <= '0;
      r_best <= '0; r_found <= 1'b0;
      out_max_value <= '0; out_x1 <= '0; out_x2 <= '0; out_feasible <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_c1 <= in_a1; r_c2 <= in_a2;
          r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
          r_sv <= '0; r_nfill <= '0;
        end
        S_LOAD: if (in_valid) begin
          if (in_a1 == c_one && in_a2 == c_zero)       r_xmax <= in_b;
          else if (in_a1 == c_mone && in_a2 == c_zero) r_xmin <= -in_b;
          else if (in_a1 == c_zero && in_a2 == c_one)  r_ymax <= in_b;
          else if (in_a1 == c_zero && in_a2 == c_mone) r_ymin <= -in_b;
          else if (r_nfill != CNT_W'(NUM_CON)) begin
            for (int i = 0; i < NUM_CON; i++) begin
              if (r_nfill == CNT_W'(i)) begin
                r_sa1[i] <= in_a1; r_sa2[i] <= in_a2; r_sb[i] <= in_b;
                r_sv[i]  <= 1'b1;
              end
            end
            r_nfill <= r_nfill + CNT_W'(1);
          end
        end else begin
          r_x <= r_xmin; r_y <= r_ymin;
          r_best <= c_min; r_bx <= '0; r_by <= '0; r_found <= 1'b0;
          if (w_empty) begin
            out_max_value <= c_min; out_x1 <= '0; out_x2 <= '0; out_feasible <= 1'b0;
          end
        end
        S_SCAN: begin
          r_best <= w_best_n; r_bx <= w_bx_n; r_by <= w_by_n; r_found <= w_found_n;
          if (r_x == r_xmax) begin
            r_x <= r_xmin;
            r_y <= r_y + B_W'(1);
          end else begin
            r_x <= r_x + B_W'(1);
          end
          if (w_last) begin
            out_max_value <= w_best_n; out_x1 <= w_bx_n; out_x2 <= w_by_n;
            out_feasible  <= w_found_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lp_box_solver.sv
`default_nettype none
// tb_lp_box_solver: directed bursts with hand-computed results; a scoreboard
// queue holds expected results and arrival cycles, checked by a monitor.
module tb_lp_box_solver;
  localparam int A_W = 6;
  localparam int B_W = 12;
  localparam int O_W = A_W + B_W + 1;
  localparam longint MINV = -(longint'(1) <<< (O_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [A_W-1:0] in_a1 = '0, in_a2 = '0;
  logic signed [B_W-1:0] in_b = '0;
  logic out_valid, out_feasible, busy;
  logic signed [O_W-1:0] out_max_value;
  logic signed [B_W-1:0] out_x1, out_x2;

  lp_box_solver #(.A_W(A_W), .B_W(B_W), .NUM_CON(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_a1(in_a1), .in_a2(in_a2), .in_b(in_b),
    .out_valid(out_valid), .out_max_value(out_max_value),
    .out_x1(out_x1), .out_x2(out_x2), .out_feasible(out_feasible), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint mx; longint x1; longint x2; longint feas; int at;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency_cycle", cyc, e.at);
        chk("max_value", longint'(out_max_value), e.mx);
        chk("x1", longint'(out_x1), e.x1);
        chk("x2", longint'(out_x2), e.x2);
        chk("feasible", longint'(out_feasible), e.feas);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic row(input int a1, input int a2, input int b);
    in_valid = 1'b1;
    in_a1 = A_W'(a1); in_a2 = A_W'(a2); in_b = B_W'(b);
    step();
  endtask

  task automatic close(input int p, input longint mx, input longint x1,
                       input longint x2, input longint feas, input bit expect_result);
    exp_t e;
    in_valid = 1'b0;
    e.mx = mx; e.x1 = x1; e.x2 = x2; e.feas = feas; e.at = cyc + p + 1;
    if (expect_result) sb.push_back(e);
  endtask

  task automatic box03();
    row(1, 0, 3); row(-1, 0, 0); row(0, 1, 3); row(0, -1, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_max"}, longint'(out_max_value), 0);
    chk({tag, "_x1"}, longint'(out_x1), 0);
    chk({tag, "_x2"}, longint'(out_x2), 0);
    chk({tag, "_feas"}, longint'(out_feasible), 0);
  endtask

  initial begin
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;

    // 1: x1+2x2<=4 over [0,3]^2, tie (2,1) loses to earlier (3,0)
    row(1, 1, 0); box03(); row(1, 2, 4);
    close(16, 3, 3, 0, 1, 1); repeat (20) step();

    // 2: infeasible slot
    row(1, 1, 0); box03(); row(1, 1, -1);
    close(16, MINV, 0, 0, 0, 1); repeat (20) step();

    // 3: negative box, c=(-1,-2): (-2,-3) gives 2+6=8
    row(-1, -2, 0); row(-1, 0, 2); row(1, 0, -1); row(0, -1, 3); row(0, 1, -3);
    close(2, 8, -2, -3, 1, 1); repeat (6) step();

    // 4: third general row (x1-x2<=-5, infeasible everywhere) must be dropped
    row(1, 1, 0); box03(); row(1, 2, 4); row(2, 1, 4); row(1, -1, -5);
    close(16, 2, 2, 0, 1, 1); repeat (20) step();

    // 5: empty box xmin=2 > xmax=1
    row(1, 1, 0); row(-1, 0, -2); row(1, 0, 1);
    close(0, MINV, 0, 0, 0, 1); repeat (4) step();

    // 7: repeated xmax row overwrites, y defaults to 0
    row(1, 0, 0); row(1, 0, 5); row(1, 0, 2);
    close(3, 2, 2, 0, 1, 1); repeat (7) step();

    // 8: zero objective, all ties keep the first scanned point
    row(0, 0, 0); row(1, 0, 1); row(0, 1, 1);
    close(4, 0, 0, 0, 1, 1); repeat (8) step();

    // 6: reset mid-SCAN aborts, then a clean rerun of problem 1
    row(1, 1, 0); box03(); row(1, 2, 4);
    close(16, 0, 0, 0, 0, 0); repeat (5) step();
    rst_n = 1'b0; step();
    check_zero("abort");
    rst_n = 1'b1;
    repeat (25) step();
    row(1, 1, 0); box03(); row(1, 2, 4);
    close(16, 3, 3, 0, 1, 1); repeat (20) step();

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
